// File: rtl/nibble_add_seq.sv
// Nibble-serial W-bit adder: one shared 4-bit padder, LSB nibble first.
// Define SUB_EN to add the two's-complement subtract path.
module padder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   x,
  input  logic [4*NIBBLES-1:0]   y,
  input  logic                   c_in,
  input  logic                   sub,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic          cy;
  logic [IW-1:0] idx;
  logic [W-1:0]  y_eff;
  logic          ci_eff;
  logic [3:0]    ps;
  logic          pc;

`ifdef SUB_EN
  assign y_eff  = y ^ {W{sub}};
  assign ci_eff = c_in ^ sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign y_eff  = y;
  assign ci_eff = c_in;
`endif

  padder4 u_pad (
    .a  (x_q[4*idx +: 4]),
    .b  (y_q[4*idx +: 4]),
    .ci (cy),
    .s  (ps),
    .co (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      cy    <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            x_q   <= x;
            y_q   <= y_eff;
            cy    <= ci_eff;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // nibble 0 also finishes the clear of sum/c_out
          if (idx == '0) begin
            sum   <= W'(ps);
            c_out <= 1'b0;
          end else begin
            sum[4*idx +: 4] <= ps;
          end
          cy <= pc;
          if (idx == LAST) begin
            idx   <= '0;
            c_out <= pc;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // result stays visible during the done pulse; RUN clears it
          if (start) begin
            x_q   <= x;
            y_q   <= y_eff;
            cy    <= ci_eff;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4: operand width in 4-bit nibbles; W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 x  input  W  operand A; sampled only on an accepted start.
REQ-006 y  input  W  operand B; sampled only on an accepted start.
REQ-007 c_in  input  1  carry into nibble 0; sampled only on an accepted start.
REQ-008 sub  input  1  subtract select; sampled only on an accepted start; ignored unless SUB_EN is defined.
REQ-009 busy  output  1  high while nibbles are being processed.
REQ-010 done  output  1  one-cycle pulse when sum and c_out are valid.
REQ-011 sum  output  W  result register.
REQ-012 c_out  output  1  carry out of the top nibble.

Function
REQ-013 Arithmetic SHALL use exactly one instance of the team's 4-bit padder, time-shared, LSB nibble first.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start.
- RUN->DONE after the nibble with index NIBBLES-1.
- DONE->RUN on start, otherwise DONE->IDLE.
REQ-015 An accepted start SHALL perform these actions:
- latch x, y, c_in and sub into internal registers;
- load the carry register with the effective carry-in;
- clear the nibble index;
- clear sum to 0.
REQ-016 Each RUN cycle SHALL perform these actions:
- present operand nibble[idx] and the carry register to the padder;
- write the padder sum into sum[4*idx+3:4*idx];
- load the padder carry into the carry register;
- increment idx.
REQ-017 Latency: with start accepted at edge k, done SHALL be high from edge k+NIBBLES+1 to edge k+NIBBLES+2; busy SHALL be high from edge k+1 to edge k+NIBBLES+1.
REQ-018 c_out SHALL update with the final nibble's carry and hold until the next accepted start clears it.
REQ-019 sum and c_out SHALL hold their values in IDLE and DONE.
REQ-020 A start in RUN SHALL be ignored: no latch, no state change, no queuing.
REQ-021 A start in DONE SHALL be accepted, giving back-to-back operation with no IDLE cycle.
REQ-022 Addition SHALL wrap modulo 2^W; overflow is reported only through c_out.
REQ-023 Operand inputs changing while busy SHALL have no effect on the result.

Reset
REQ-024 While rst_n is low, the block SHALL hold these values:
- state = IDLE, idx = 0, carry register = 0;
- busy = 0, done = 0, sum = 0, c_out = 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-026 The first accepted start SHALL be on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro SUB_EN defined: the block SHALL apply the following subtract rules:
- effective y = y XOR {W{sub}};
- effective carry-in = c_in XOR sub;
- sub=1, c_in=0 computes x-y; c_out=1 means no borrow.
REQ-028 Macro SUB_EN undefined: the block SHALL apply the following add-only rules:
- sub is ignored;
- effective y = y and effective carry-in = c_in;
- no subtract logic is synthesized.

Verification (NIBBLES=4)
REQ-029 Basic add: x=0x1234, y=0x0FFF, c_in=0, start pulse -> busy high for 4 cycles, then done pulse; sum=0x2233, c_out=0.
REQ-030 Full carry ripple: x=0xFFFF, y=0x0001, c_in=0 -> sum=0x0000, c_out=1; x=0xFFFF, y=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
REQ-031 Start while busy: start at cycle 0 with 0x0001+0x0001, start again at cycle 2 with 0x0F0F+0x0101 -> a single done pulse with sum=0x0002; the second start is dropped.
REQ-032 Reset mid-operation: drop rst_n in the second RUN cycle -> all outputs 0 immediately, no done pulse; a following 0x00A0+0x0005 gives sum=0x00A5.
REQ-033 Back-to-back: start held high across the DONE cycle -> the second operation's done arrives exactly 5 cycles after the first done, with no busy-low gap beyond the DONE cycle.
REQ-034 SUB_EN defined: x=0x0005, y=0x0007, sub=1, c_in=0 -> sum=0xFFFE, c_out=0; with x=0x0007, y=0x0005 -> sum=0x0002, c_out=1.
